// File: rtl/gr_wb_sched_if.sv
// Bundle of the GR write-back scheduler signals: producer requests, flush and the
// registered write-port controls returned to producers and the register file.
interface gr_wb_sched_if #(
    parameter int NSRC = 7,
    parameter int AW   = 5
);
    logic [NSRC-1:0]    req;
    logic [NSRC*AW-1:0] req_waddr;
    logic               flush;
    logic [NSRC-1:0]    ack;
    logic [2:0]         MUX_GR_W_DATA;
    logic               GR_WE;
    logic [AW-1:0]      GR_WADDR;
    logic               busy;

    modport master (
        output req, req_waddr, flush,
        input  ack, MUX_GR_W_DATA, GR_WE, GR_WADDR, busy
    );

    modport slave (
        input  req, req_waddr, flush,
        output ack, MUX_GR_W_DATA, GR_WE, GR_WADDR, busy
    );
endinterface

// File: rtl/gr_wb_sched.sv
// Round-robin write-back scheduler for the GR file write port: grants one producer per
// cycle and drives the registered write-data select, write enable and write address.
module gr_wb_sched #(
    parameter int NSRC = 7,
    parameter int AW   = 5
) (
    input  logic         clk,
    input  logic         rst,
    gr_wb_sched_if.slave bus
);
    localparam logic [2:0] SEL_NONE = 3'd7;

    logic [NSRC-1:0] ack_q, ack_d;
    logic [2:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;

    logic [NSRC-1:0] elig;
    logic            win_found;
    logic [2:0]      win_idx;
    logic [2:0]      cand;
    logic [AW-1:0]   win_waddr;
    logic            grant;

    always_comb begin
        // The source acked this cycle may still hold req; masking it avoids a repeat grant.
        elig      = bus.req & ~ack_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand = 3'((32'(rr_ptr_q) + k) % NSRC);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_waddr = bus.req_waddr[int'(win_idx)*AW +: AW];
        grant     = win_found & ~bus.flush;

        ack_d    = '0;
        sel_d    = SEL_NONE;
        we_d     = 1'b0;
        waddr_d  = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            ack_d[win_idx] = 1'b1;
            sel_d          = win_idx;
            we_d           = (win_waddr != '0);
            waddr_d        = win_waddr;
            rr_ptr_d       = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= '0;
            sel_q    <= SEL_NONE;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            rr_ptr_q <= 3'(NSRC - 1);
        end else begin
            ack_q    <= ack_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.MUX_GR_W_DATA = sel_q;
    assign bus.GR_WE         = we_q;
    assign bus.GR_WADDR      = waddr_q;
    assign bus.busy          = |(bus.req & ~ack_d);

    ack_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));
    we_implies_ack_a : assert property (@(posedge clk) disable iff (rst) we_q |-> (ack_q != '0));
endmodule
